cordic_iter: RTL and testbench
==============================

CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 SHALL have parameter N, default 32: datapath width, Q4.28 fixed point when 32.
REQ-002 SHALL have parameter ITER, default 28: number of micro-rotations, legal range 1..N-4.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports x_in, y_in, z_in  input  N each  signed operands; z_in is an angle in radians, within ±pi/2.
REQ-006 SHALL have port in_valid  input  1  operands valid.
REQ-007 SHALL have port in_ready  output  1  block can accept operands.
REQ-008 SHALL have ports x_out, y_out, z_out  output  N each  signed results, unscaled (gain about 1.6467602), for the downstream gain-correction stage.
REQ-009 SHALL have port out_valid  output  1  results valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts results.

Function
REQ-011 SHALL implement an FSM with states IDLE, ROTATE and DONE.
REQ-012 SHALL transition from IDLE to ROTATE when in_valid and in_ready are both high: operands registered, iteration counter i = 0.
REQ-013 SHALL hold in_ready high in IDLE only; in_valid in other states SHALL be ignored and the operands not captured.
REQ-014 SHALL perform one micro-rotation per cycle in ROTATE:
- d = +1 if z >= 0, else -1.
- x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan(2^-i).
REQ-015 SHALL use arithmetic right shifts; add and subtract SHALL wrap modulo 2^N with no saturation.
REQ-016 SHALL transition from ROTATE to DONE after the micro-rotation with i = ITER-1; out_valid SHALL be high exactly ITER cycles after the accepting edge.
REQ-017 SHALL keep x_out, y_out, z_out equal to the working registers, and stable while in DONE.
REQ-018 SHALL transition from DONE to IDLE when out_ready is high; out_valid SHALL fall on the same edge.
REQ-019 SHALL hold results and out_valid while out_ready is low, indefinitely.
REQ-020 SHALL NOT overlap operations: a new accept occurs no earlier than the cycle after DONE exits.
REQ-021 SHALL take the atan(2^-i) constants in Q4.28, rounded to nearest, indexed by i.

Reset
REQ-022 SHALL, while rst_n is low, asynchronously force: state = IDLE, i = 0, x/y/z registers = 0, out_valid = 0, in_ready = 0.
REQ-023 SHALL set in_ready high on the first rising edge after rst_n is released.
REQ-024 SHALL abandon an in-flight operation on reset mid-operation and produce no out_valid for it.

Configuration
REQ-025 SHALL use macro CORDIC_VECTORING_EN.
REQ-026 With CORDIC_VECTORING_EN defined, SHALL add port mode_in  input  1 (0 = rotation, 1 = vectoring), captured on accept.
REQ-027 In vectoring mode, SHALL set d = +1 when y < 0, else -1, driving y toward 0 and accumulating the angle into z.
REQ-028 With CORDIC_VECTORING_EN undefined, SHALL omit mode_in and support rotation mode only.

Structure
REQ-029 SHALL place N, the default ITER, the Q4.28 constants (pi/2, gain) and the atan table in shared package cordic_pkg.
REQ-030 SHALL place the atan lookup in sub-module cordic_atan_lut: combinational, index in, N-bit constant out.
REQ-031 SHALL keep FSM, counter and datapath in cordic_iter.

Verification
REQ-032 Rotate x=0x10000000, y=0, z=0 -> x_out ≈ 442048819 ±64 LSB, y_out ≈ 0 ±64 LSB, out_valid exactly 28 cycles after accept.
REQ-033 Rotate x=0x10000000, y=0, z=421657428 (pi/2) -> x_out ≈ 0 ±64 LSB, y_out ≈ 442048819 ±64 LSB, |z_out| ≤ 64 LSB.
REQ-034 Hold out_ready low 10 cycles in DONE with in_valid high -> outputs stable, in_ready low, no second accept; on out_ready high -> IDLE, next accept on the following cycle.
REQ-035 Assert rst_n low at i = 10 -> all outputs 0 immediately, no out_valid; a fresh operation then completes correctly.
REQ-036 With CORDIC_VECTORING_EN defined: vectoring x=0x10000000, y=0x10000000 -> z_out ≈ 210828714 (pi/4) ±64 LSB, y_out ≈ 0 ±64 LSB.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC: datapath width, default
// iteration count, Q4.28 constants and the atan(2^-i) table.
package cordic_pkg;

    localparam int unsigned CORDIC_N     = 32;
    localparam int unsigned CORDIC_ITER  = 28;
    localparam int unsigned CORDIC_IDX_W = 5;

    localparam logic signed [31:0] CORDIC_HALF_PI = 32'sd421657428;
    localparam logic signed [31:0] CORDIC_GAIN    = 32'sd442048819;

    // atan(2^-i) in Q4.28, rounded to nearest; entries past i=28 round to zero
    function automatic logic [31:0] cordic_atan_q28(input logic [CORDIC_IDX_W-1:0] idx);
        logic [31:0] v;
        v = 32'd0;
        case (idx)
            5'd0:  v = 32'd210828714;
            5'd1:  v = 32'd124459457;
            5'd2:  v = 32'd65760959;
            5'd3:  v = 32'd33381290;
            5'd4:  v = 32'd16755422;
            5'd5:  v = 32'd8385879;
            5'd6:  v = 32'd4193963;
            5'd7:  v = 32'd2097109;
            5'd8:  v = 32'd1048571;
            5'd9:  v = 32'd524287;
            5'd10: v = 32'd262144;
            5'd11: v = 32'd131072;
            5'd12: v = 32'd65536;
            5'd13: v = 32'd32768;
            5'd14: v = 32'd16384;
            5'd15: v = 32'd8192;
            5'd16: v = 32'd4096;
            5'd17: v = 32'd2048;
            5'd18: v = 32'd1024;
            5'd19: v = 32'd512;
            5'd20: v = 32'd256;
            5'd21: v = 32'd128;
            5'd22: v = 32'd64;
            5'd23: v = 32'd32;
            5'd24: v = 32'd16;
            5'd25: v = 32'd8;
            5'd26: v = 32'd4;
            5'd27: v = 32'd2;
            5'd28: v = 32'd1;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational atan(2^-i) lookup, Q4.28 constant for micro-rotation index idx.
module cordic_atan_lut
    import cordic_pkg::*;
#(
    parameter int unsigned N = CORDIC_N
) (
    input  logic [CORDIC_IDX_W-1:0] idx,
    output logic [N-1:0]            atan_c
);

    assign atan_c = N'(cordic_atan_q28(idx));

endmodule

// File: rtl/cordic_iter.sv
// Iterative CORDIC, one micro-rotation per cycle, unscaled outputs.
// Optional vectoring mode (mode_in) enabled by CORDIC_VECTORING_EN.
module cordic_iter
    import cordic_pkg::*;
#(
    parameter int unsigned N    = CORDIC_N,
    parameter int unsigned ITER = CORDIC_ITER
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CORDIC_VECTORING_EN
    input  logic                mode_in,
`endif
    input  logic signed [N-1:0] x_in,
    input  logic signed [N-1:0] y_in,
    input  logic signed [N-1:0] z_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [N-1:0] x_out,
    output logic signed [N-1:0] y_out,
    output logic signed [N-1:0] z_out,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROTATE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]          state_q;
    logic [1:0]          state_nxt;
    logic [CW-1:0]       cnt_q;
    logic signed [N-1:0] x_q;
    logic signed [N-1:0] y_q;
    logic signed [N-1:0] z_q;
    logic signed [N-1:0] atan_c;
    logic signed [N-1:0] x_sh_c;
    logic signed [N-1:0] y_sh_c;
    logic                d_pos_c;
    logic                accept_c;
    logic                last_c;

    cordic_atan_lut #(.N(N)) u_atan_lut (
        .idx    (CORDIC_IDX_W'(cnt_q)),
        .atan_c (atan_c)
    );

    assign accept_c = (state_q == ST_IDLE) && in_valid && in_ready;
    assign last_c   = (cnt_q == CW'(ITER - 1));
    assign x_sh_c   = x_q >>> cnt_q;
    assign y_sh_c   = y_q >>> cnt_q;

`ifdef CORDIC_VECTORING_EN
    logic mode_q;
    // vectoring steers y toward zero; rotation steers z toward zero
    assign d_pos_c = mode_q ? y_q[N-1] : ~z_q[N-1];
`else
    assign d_pos_c = ~z_q[N-1];
`endif

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c)  state_nxt = ST_ROTATE;
            ST_ROTATE: if (last_c)    state_nxt = ST_DONE;
            ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State and handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            in_ready  <= (state_nxt == ST_IDLE);
            out_valid <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
`ifdef CORDIC_VECTORING_EN
            mode_q <= 1'b0;
`endif
        end else if (accept_c) begin
            cnt_q  <= '0;
            x_q    <= x_in;
            y_q    <= y_in;
            z_q    <= z_in;
`ifdef CORDIC_VECTORING_EN
            mode_q <= mode_in;
`endif
        end else if (state_q == ST_ROTATE) begin
            if (d_pos_c) begin
                x_q <= x_q - y_sh_c;
                y_q <= y_q + x_sh_c;
                z_q <= z_q - atan_c;
            end else begin
                x_q <= x_q + y_sh_c;
                y_q <= y_q - x_sh_c;
                z_q <= z_q + atan_c;
            end
            cnt_q <= last_c ? '0 : cnt_q + CW'(1);
        end
    end

    assign x_out = x_q;
    assign y_out = y_q;
    assign z_out = z_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Randomized bench for cordic_iter against an ideal real-valued rotation model.
module tb_cordic_iter;

    localparam int  ITER = 28;
    localparam real Q    = 268435456.0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] x_in, y_in, z_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_out, y_out, z_out;
    logic        out_valid;
    logic        out_ready;
`ifdef CORDIC_VECTORING_EN
    logic        mode_in;
`endif

    int  n_checks = 0;
    int  n_errors = 0;
    real kgain;

    always #5 clk = ~clk;

    cordic_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef CORDIC_VECTORING_EN
        .mode_in   (mode_in),
`endif
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
        longint diff;
        n_checks++;
        diff = obs - exp;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    // Ideal CORDIC result: exact rotation / polar conversion scaled by the gain
    task automatic model(input longint xi, input longint yi, input longint zi, input logic md,
                         output longint ex, output longint ey, output longint ez);
        real xr, yr, zr;
        xr = real'(xi);
        yr = real'(yi);
        zr = real'(zi) / Q;
        if (md) begin
            ex = longint'(kgain * $sqrt(xr * xr + yr * yr));
            ey = 0;
            ez = longint'(real'(zi) + $atan(yr / xr) * Q);
        end else begin
            ex = longint'(kgain * (xr * $cos(zr) - yr * $sin(zr)));
            ey = longint'(kgain * (yr * $cos(zr) + xr * $sin(zr)));
            ez = 0;
        end
    endtask

    task automatic do_op(input string tag, input longint xi, input longint yi, input longint zi,
                         input logic md, input int hold,
                         input longint ex, input longint ey, input longint ez, input longint tol);
        int guard;
        int lat;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, longint'(in_ready), 1, 0);
        x_in = 32'(xi);
        y_in = 32'(yi);
        z_in = 32'(zi);
`ifdef CORDIC_VECTORING_EN
        mode_in = md;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        // junk operands with in_valid held high must be ignored while busy
        x_in = $urandom;
        y_in = $urandom;
        z_in = $urandom;
        @(negedge clk);
        check({tag, "_busy"}, longint'(in_ready), 0, 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < ITER + 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, longint'(lat), longint'(ITER), 0);
        check({tag, "_x"}, sx(x_out), ex, tol);
        check({tag, "_y"}, sx(y_out), ey, tol);
        check({tag, "_z"}, sx(z_out), ez, tol);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_v"}, longint'(out_valid), 1, 0);
            check({tag, "_hold_rdy"}, longint'(in_ready), 0, 0);
            check({tag, "_hold_x"}, sx(x_out), ex, tol);
            check({tag, "_hold_y"}, sx(y_out), ey, tol);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_exit_v"}, longint'(out_valid), 0, 0);
        check({tag, "_exit_rdy"}, longint'(in_ready), 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        longint xi, yi, zi, ex, ey, ez;
        int     hold;
        int     seen;

        kgain = 1.0;
        for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
`ifdef CORDIC_VECTORING_EN
        mode_in   = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst_rdy", longint'(in_ready), 0, 0);
        check("rst_v", longint'(out_valid), 0, 0);
        check("rst_x", sx(x_out), 0, 0);
        check("rst_z", sx(z_out), 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rel_rdy_pre", longint'(in_ready), 0, 0);
        @(posedge clk);
        #1;
        check("rel_rdy", longint'(in_ready), 1, 0);

        do_op("rot0", 268435456, 0, 0, 1'b0, 0, 442048819, 0, 0, 64);
        do_op("rot90", 268435456, 0, 421657428, 1'b0, 2, 0, 442048819, 0, 64);

        xi = 134217728; yi = 67108864; zi = -300000000;
        model(xi, yi, zi, 1'b0, ex, ey, ez);
        do_op("hold10", xi, yi, zi, 1'b0, 10, ex, ey, ez, 64);
        // back-to-back accept right after DONE exit
        do_op("b2b", 268435456, 0, 0, 1'b0, 0, 442048819, 0, 0, 64);

        // reset while iteration 10 is pending
        x_in = 32'd268435456; y_in = '0; z_in = 32'd200000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_v", longint'(out_valid), 0, 0);
        check("mid_rst_rdy", longint'(in_ready), 0, 0);
        check("mid_rst_x", sx(x_out), 0, 0);
        check("mid_rst_y", sx(y_out), 0, 0);
        check("mid_rst_z", sx(z_out), 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (ITER + 4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_valid", longint'(seen), 0, 0);
        do_op("post_rst", 268435456, 0, 0, 1'b0, 0, 442048819, 0, 0, 64);

        for (int n = 0; n < 8; n++) begin
            xi   = longint'($urandom_range(0, 268435456)) - 134217728;
            yi   = longint'($urandom_range(0, 268435456)) - 134217728;
            zi   = longint'($urandom_range(0, 843314856)) - 421657428;
            hold = int'($urandom_range(0, 3));
            model(xi, yi, zi, 1'b0, ex, ey, ez);
            do_op("rand_rot", xi, yi, zi, 1'b0, hold, ex, ey, ez, 64);
        end

`ifdef CORDIC_VECTORING_EN
        model(268435456, 268435456, 0, 1'b1, ex, ey, ez);
        do_op("vec45", 268435456, 268435456, 0, 1'b1, 1, ex, 0, 210828714, 64);
        for (int n = 0; n < 4; n++) begin
            xi = longint'($urandom_range(67108864, 134217728));
            yi = longint'($urandom_range(0, 268435456)) - 134217728;
            model(xi, yi, 0, 1'b1, ex, ey, ez);
            do_op("rand_vec", xi, yi, 0, 1'b1, 0, ex, ey, ez, 64);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
